// File: rtl/conv_scheduler.sv
// conv_scheduler: walks the dual-output 3x3 convolution engine across an IMG_W x IMG_W map,
// one engine job per horizontal output pair, packing the sums densely into result memory.
module conv_scheduler #(
    parameter int unsigned IMG_W   = 28,
    parameter int unsigned K       = 3,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_src_base,
    input  logic [ADDR_W-1:0] i_kern_base,
    input  logic [ADDR_W-1:0] i_dst_base,
    input  logic [2:0]        i_stride,
    output logic              o_eng_start,
    output logic [ADDR_W-1:0] o_eng_src_addr,
    output logic [ADDR_W-1:0] o_eng_kern_addr,
    output logic [2:0]        o_eng_stride,
    input  logic              i_eng_done,
    input  logic [7:0]        i_eng_sum1,
    input  logic [7:0]        i_eng_sum2,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned   CW    = ADDR_W + 1;
    localparam int unsigned   TW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ImgW  = CW'(IMG_W);
    localparam logic [CW-1:0] KW    = CW'(K);
    localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWait, StWr1, StWr2, StNext, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_base_q, src_base_d;
    logic [ADDR_W-1:0]   kern_q, kern_d;
    logic [2:0]          stride_q, stride_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [7:0]          sum2_q, sum2_d;
    logic                pair_q, pair_d;
    logic                start_q, start_d;
    logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [CW-1:0]       ncol;

    always_comb begin
        state_d    = state_q;
        src_base_d = src_base_q;
        kern_d     = kern_q;
        stride_d   = stride_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        dst_ptr_d  = dst_ptr_q;
        timer_d    = timer_q;
        sum2_d     = sum2_q;
        pair_d     = pair_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        ncol       = {1'b0, col_q} + (CW'(stride_q) << 1);

        case (state_q)
            StIdle: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    if (i_stride == 3'd0) begin
                        err_d = 1'b1;
                    end else begin
                        src_base_d = i_src_base;
                        kern_d     = i_kern_base;
                        stride_d   = i_stride;
                        row_d      = '0;
                        col_d      = '0;
                        row_base_d = '0;
                        dst_ptr_d  = i_dst_base;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (i_eng_done) begin
                    sum2_d    = i_eng_sum2;
                    pair_d    = ({1'b0, col_q} + CW'(stride_q) + KW) <= ImgW;
                    wr_en_d   = 1'b1;
                    wr_addr_d = dst_ptr_q;
                    wr_data_d = i_eng_sum1;
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    state_d   = StWr1;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_d == TLast) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWr1: begin
                if (pair_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = dst_ptr_q;
                    wr_data_d = sum2_q;
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    state_d   = StWr2;
                end else begin
                    state_d = StNext;
                end
            end
            StWr2: state_d = StNext;
            StNext: begin
                if (ncol + KW <= ImgW) begin
                    col_d   = ncol[ADDR_W-1:0];
                    state_d = StIssue;
                end else begin
                    col_d      = '0;
                    row_d      = row_q + ADDR_W'(stride_q);
                    row_base_d = row_base_q + ADDR_W'(stride_q) * ADDR_W'(IMG_W);
                    // Bound check uses the row just finished, in CW bits so wrap cannot pass.
                    if (({1'b0, row_q} + CW'(stride_q) + KW) > ImgW) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered so they line up with the state they belong to.
        start_d     = (state_d == StIssue);
        src_addr_d  = (state_d == StIssue) ? (src_base_d + row_base_d + col_d) : src_addr_q;
        done_d      = (state_d == StDone);
        busy_d      = (state_d != StIdle);
        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            src_base_q  <= '0;
            kern_q      <= '0;
            stride_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            row_base_q  <= '0;
            dst_ptr_q   <= '0;
            timer_q     <= '0;
            sum2_q      <= '0;
            pair_q      <= 1'b0;
            start_q     <= 1'b0;
            src_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            src_base_q  <= src_base_d;
            kern_q      <= kern_d;
            stride_q    <= stride_d;
            row_q       <= row_d;
            col_q       <= col_d;
            row_base_q  <= row_base_d;
            dst_ptr_q   <= dst_ptr_d;
            timer_q     <= timer_d;
            sum2_q      <= sum2_d;
            pair_q      <= pair_d;
            start_q     <= start_d;
            src_addr_q  <= src_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign o_cmd_ready     = cmd_ready_q;
    assign o_eng_start     = start_q;
    assign o_eng_src_addr  = src_addr_q;
    assign o_eng_kern_addr = kern_q;
    assign o_eng_stride    = stride_q;
    assign o_wr_en         = wr_en_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: an engine model answers jobs, and a layer-level model of the
// expected job addresses and packed result writes is checked against the DUT every cycle.
module tb_conv_scheduler;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [9:0] i_src_base, i_kern_base, i_dst_base;
    logic [2:0] i_stride;
    logic       o_eng_start;
    logic [9:0] o_eng_src_addr, o_eng_kern_addr;
    logic [2:0] o_eng_stride;
    logic       i_eng_done;
    logic [7:0] i_eng_sum1, i_eng_sum2;
    logic       o_wr_en;
    logic [9:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_busy, o_done, o_err;

    conv_scheduler dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_src_base     (i_src_base),
        .i_kern_base    (i_kern_base),
        .i_dst_base     (i_dst_base),
        .i_stride       (i_stride),
        .o_eng_start    (o_eng_start),
        .o_eng_src_addr (o_eng_src_addr),
        .o_eng_kern_addr(o_eng_kern_addr),
        .o_eng_stride   (o_eng_stride),
        .i_eng_done     (i_eng_done),
        .i_eng_sum1     (i_eng_sum1),
        .i_eng_sum2     (i_eng_sum2),
        .o_wr_en        (o_wr_en),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int n_start, n_wr, n_done, n_errp, last_wa_seen;
    int cur_kern, cur_stride;
    int exp_src[$], exp_wa[$], exp_wd[$], starts[$];
    bit eng_mute = 1'b0;
    int eng_cnt = 0;
    logic [9:0] eng_job;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Arbitrary but address-dependent engine results, so misplaced data is visible.
    function automatic logic [7:0] f1(input int a);
        int v;
        v = (a % 1024) * 7 + 1;
        return v[7:0];
    endfunction

    function automatic logic [7:0] f2(input int a);
        int v;
        v = (a % 1024) * 5 + 3;
        return v[7:0];
    endfunction

    // Layer model: output grid n x n at pixel (y*s, x*s); even x starts a job, odd x is its sum2.
    task automatic plan(input int src, input int dst, input int s);
        int n, p, r, c;
        n = (28 - 3) / s + 1;
        p = dst;
        exp_src.delete();
        exp_wa.delete();
        exp_wd.delete();
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                r = y * s;
                c = x * s;
                if (x % 2 == 0) begin
                    exp_src.push_back((src + r * 28 + c) % 1024);
                    exp_wd.push_back(f1(src + r * 28 + c));
                end else begin
                    exp_wd.push_back(f2(src + r * 28 + c - s));
                end
                exp_wa.push_back(p % 1024);
                p++;
            end
        end
    endtask

    // Engine model: done pulse 12 cycles after each start.
    always @(negedge clk) begin
        if (i_rst) begin
            eng_cnt = 0;
            i_eng_done = 1'b0;
        end else begin
            i_eng_done = 1'b0;
            if (o_eng_start && !eng_mute) begin
                eng_cnt = 12;
                eng_job = o_eng_src_addr;
            end else if (eng_cnt != 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    i_eng_done = 1'b1;
                    i_eng_sum1 = f1(int'(eng_job));
                    i_eng_sum2 = f2(int'(eng_job));
                end
            end
        end
    end

    // Compare process.
    always @(negedge clk) begin
        if (!i_rst) begin
            check("start_wr_overlap", int'(o_eng_start & o_wr_en), 0);
            check("ready_vs_busy", int'(o_cmd_ready), int'(!o_busy));
            if (o_eng_start) begin
                n_start++;
                starts.push_back(int'(o_eng_src_addr));
                if (exp_src.size() == 0) fail_now("extra_start");
                else check("eng_src_addr", int'(o_eng_src_addr), exp_src.pop_front());
                check("eng_kern_addr", int'(o_eng_kern_addr), cur_kern);
                check("eng_stride", int'(o_eng_stride), cur_stride);
            end
            if (o_wr_en) begin
                n_wr++;
                last_wa_seen = int'(o_wr_addr);
                if (exp_wa.size() == 0) begin
                    fail_now("extra_write");
                end else begin
                    check("wr_addr", int'(o_wr_addr), exp_wa.pop_front());
                    check("wr_data", int'(o_wr_data), exp_wd.pop_front());
                end
            end
            if (o_done) n_done++;
            if (o_err) n_errp++;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, int'(o_cmd_ready), 1);
        check({tag, "_busy"}, int'(o_busy), 0);
        check({tag, "_start"}, int'(o_eng_start), 0);
        check({tag, "_src_addr"}, int'(o_eng_src_addr), 0);
        check({tag, "_kern_addr"}, int'(o_eng_kern_addr), 0);
        check({tag, "_stride"}, int'(o_eng_stride), 0);
        check({tag, "_wr_en"}, int'(o_wr_en), 0);
        check({tag, "_wr_addr"}, int'(o_wr_addr), 0);
        check({tag, "_wr_data"}, int'(o_wr_data), 0);
        check({tag, "_done"}, int'(o_done), 0);
        check({tag, "_err"}, int'(o_err), 0);
    endtask

    task automatic send_cmd(input int src, input int kern, input int dst, input int s);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_src_base  = 10'(src);
        i_kern_base = 10'(kern);
        i_dst_base  = 10'(dst);
        i_stride    = 3'(s);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic clear_counts();
        n_start = 0;
        n_wr = 0;
        n_done = 0;
        n_errp = 0;
        last_wa_seen = -1;
        starts.delete();
    endtask

    task automatic run_layer(input int src, input int kern, input int dst, input int s,
                             input int jobs, input int writes, input int last_wa);
        bit got_done, got_err;
        clear_counts();
        plan(src, dst, s);
        cur_kern = kern;
        cur_stride = s;
        send_cmd(src, kern, dst, s);
        got_done = 1'b0;
        got_err = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (o_done) begin got_done = 1'b1; break; end
            if (o_err) begin got_err = 1'b1; break; end
        end
        check("layer_done_seen", int'(got_done), 1);
        check("layer_err_seen", int'(got_err), 0);
        @(negedge clk);
        check("done_one_cycle", int'(o_done), 0);
        check("done_pulses", n_done, 1);
        check("err_pulses", n_errp, 0);
        check("job_count", n_start, jobs);
        check("write_count", n_wr, writes);
        check("jobs_left", exp_src.size(), 0);
        check("writes_left", exp_wa.size(), 0);
        check("last_wr_addr", last_wa_seen, last_wa);
        check("ready_after_layer", int'(o_cmd_ready), 1);
    endtask

    initial begin
        int t0, t1;
        bit seen;
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_src_base = '0;
        i_kern_base = '0;
        i_dst_base = '0;
        i_stride = '0;
        i_eng_done = 1'b0;
        i_eng_sum1 = '0;
        i_eng_sum2 = '0;
        clear_counts();
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;

        // Stride 1: 13 jobs per row, all paired.
        run_layer(0, 900, 100, 1, 338, 676, 775);
        check("s1_job1_src", starts[1], 2);
        check("s1_job13_src", starts[13], 28);

        // Stride 2: last job of each row is single.
        run_layer(0, 900, 100, 2, 91, 169, 268);
        check("s2_row2_src", starts[7], 56);

        run_layer(30, 17, 0, 3, 45, 81, 80);
        run_layer(5, 3, 600, 7, 8, 16, 615);

        // Illegal stride is rejected with a one-cycle error.
        clear_counts();
        send_cmd(0, 0, 0, 0);
        check("s0_err", int'(o_err), 1);
        check("s0_busy", int'(o_busy), 0);
        @(negedge clk);
        check("s0_err_one_cycle", int'(o_err), 0);
        check("s0_busy_after", int'(o_busy), 0);
        check("s0_no_start", n_start, 0);
        run_layer(0, 1, 200, 7, 8, 16, 215);

        // Engine never answers: abort after TIMEOUT cycles.
        clear_counts();
        plan(0, 0, 1);
        cur_kern = 9;
        cur_stride = 1;
        eng_mute = 1'b1;
        send_cmd(0, 9, 0, 1);
        seen = 1'b0;
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_eng_start) begin seen = 1'b1; t0 = cyc; break; end
            @(negedge clk);
        end
        check("to_start_seen", int'(seen), 1);
        seen = 1'b0;
        t1 = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_err) begin seen = 1'b1; t1 = cyc; break; end
        end
        check("to_err_seen", int'(seen), 1);
        check("to_latency", t1 - t0, 64);
        @(negedge clk);
        check("to_ready", int'(o_cmd_ready), 1);
        check("to_no_done", n_done, 0);
        check("to_err_pulses", n_errp, 1);
        check("to_jobs", n_start, 1);
        check("to_writes", n_wr, 0);
        eng_mute = 1'b0;

        // Reset in the fifth WAIT.
        clear_counts();
        plan(0, 0, 1);
        cur_kern = 4;
        cur_stride = 1;
        send_cmd(0, 4, 0, 1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (n_start >= 5) break;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_jobs_before", n_start, 5);
        check("rst_writes_before", n_wr, 8);
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        check("midrst_no_done", n_done, 0);
        check("midrst_no_err", n_errp, 0);
        run_layer(0, 900, 500, 7, 8, 16, 515);
        check("restart_src", starts[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
